// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage/branch inputs and pipeline control outputs of the hazard/forwarding controller.
// master drives the ID bundle and branch result; slave is the controller.
interface hazard_fwd_ctrl_if;
    logic       id_valid;
    logic [1:0] id_rs1;
    logic [1:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [1:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       ex_br_taken;
    logic       pc_write_en;
    logic       if_id_write_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall_active;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
        output ex_br_taken,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        input  fwd_a_sel, fwd_b_sel, stall_active
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
        input  ex_br_taken,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        output fwd_a_sel, fwd_b_sel, stall_active
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 8-bit 5-stage core: EX operand forwarding, load-use stall
// sequencing and taken-branch flush, all combinational from slot state and ID inputs.
module hazard_fwd_ctrl #(
    parameter int unsigned LOAD_USE_STALLS = 1,
    parameter bit          ZERO_REG_EN     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    hazard_fwd_ctrl_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic [1:0] rd;
        logic       we;
        logic       is_load;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] rd;
        logic       we;
    } wr_slot_t;

    typedef enum logic [0:0] {StIdle, StStall} state_t;

    // First STALL-state count; only meaningful when more than one bubble is needed.
    localparam logic [1:0] CntInit = (LOAD_USE_STALLS > 1) ? 2'(LOAD_USE_STALLS - 2) : 2'd0;

    ex_slot_t   ex_q, ex_d;
    wr_slot_t   mem_q, wb_q;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hazard, stall;

    function automatic logic reg_match(input logic [1:0] a, input logic [1:0] b);
        return (a == b) && !(ZERO_REG_EN && (a == 2'd0));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [1:0] rs,
                                           input ex_slot_t ex, input wr_slot_t mem,
                                           input wr_slot_t wb);
        if (!ex.valid || !used) return 2'b00;
        if (mem.valid && mem.we && reg_match(mem.rd, rs)) return 2'b01;
        if (wb.valid && wb.we && reg_match(wb.rd, rs)) return 2'b10;
        return 2'b00;
    endfunction

    assign bus.fwd_a_sel = fwd_sel(ex_q.rs1_used, ex_q.rs1, ex_q, mem_q, wb_q);
    assign bus.fwd_b_sel = fwd_sel(ex_q.rs2_used, ex_q.rs2, ex_q, mem_q, wb_q);

    assign hazard = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.we &&
                    ((bus.id_rs1_used && reg_match(bus.id_rs1, ex_q.rd)) ||
                     (bus.id_rs2_used && reg_match(bus.id_rs2, ex_q.rd)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (bus.ex_br_taken) begin
            // Branch wins over any hazard or pending stall.
            state_d = StIdle;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hazard) begin
                        stall = 1'b1;
                        if (LOAD_USE_STALLS > 1) begin
                            state_d = StStall;
                            cnt_d   = CntInit;
                        end
                    end
                end
                StStall: begin
                    stall = 1'b1;
                    if (cnt_q == 2'd0) state_d = StIdle;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                default: state_d = StIdle;
            endcase
        end

        bus.pc_write_en    = !stall;
        bus.if_id_write_en = !stall;
        bus.if_id_flush    = bus.ex_br_taken;
        bus.id_ex_bubble   = bus.ex_br_taken || stall;
        bus.stall_active   = stall;

        ex_d = '{valid:    bus.id_valid && !bus.id_ex_bubble,
                 rd:       bus.id_rd,
                 we:       bus.id_we,
                 is_load:  bus.id_is_load,
                 rs1:      bus.id_rs1,
                 rs2:      bus.id_rs2,
                 rs1_used: bus.id_rs1_used,
                 rs2_used: bus.id_rs2_used};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q.valid  <= 1'b0;
            mem_q.valid <= 1'b0;
            wb_q.valid  <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Drives three controller configurations with shared stimulus; each is checked every cycle
// against an instruction-level pipeline model, plus directed checks from the test plan.
module tb_hazard_fwd_ctrl;

    typedef struct {
        bit         valid;
        logic [1:0] rd;
        bit         we;
        bit         ld;
        logic [1:0] rs1;
        logic [1:0] rs2;
        bit         u1;
        bit         u2;
    } ins_t;

    // Config 0: 1 stall; config 1: 3 stalls; config 2: 2 stalls with R0 masking.
    int unsigned stalls [3] = '{1, 3, 2};
    bit          zen    [3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, br;
    logic [1:0] id_rs1, id_rs2, id_rd;

    logic       o_pcwe [3], o_ifwe [3], o_flush [3], o_bub [3], o_stall [3];
    logic [1:0] o_fa [3], o_fb [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the instruction occupying each stage, plus remaining forced stall cycles.
    ins_t m_ex [3], m_mem [3], m_wb [3];
    int   left [3];

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_conn
        assign bus[g].id_valid    = id_valid;
        assign bus[g].id_rs1      = id_rs1;
        assign bus[g].id_rs2      = id_rs2;
        assign bus[g].id_rs1_used = id_rs1_used;
        assign bus[g].id_rs2_used = id_rs2_used;
        assign bus[g].id_rd       = id_rd;
        assign bus[g].id_we       = id_we;
        assign bus[g].id_is_load  = id_is_load;
        assign bus[g].ex_br_taken = br;
        assign o_pcwe[g]  = bus[g].pc_write_en;
        assign o_ifwe[g]  = bus[g].if_id_write_en;
        assign o_flush[g] = bus[g].if_id_flush;
        assign o_bub[g]   = bus[g].id_ex_bubble;
        assign o_stall[g] = bus[g].stall_active;
        assign o_fa[g]    = bus[g].fwd_a_sel;
        assign o_fb[g]    = bus[g].fwd_b_sel;
    end

    hazard_fwd_ctrl #(.LOAD_USE_STALLS(1), .ZERO_REG_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus[0]));
    hazard_fwd_ctrl #(.LOAD_USE_STALLS(3), .ZERO_REG_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus[1]));
    hazard_fwd_ctrl #(.LOAD_USE_STALLS(2), .ZERO_REG_EN(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus[2]));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit same(int k, logic [1:0] a, logic [1:0] b);
        return (a == b) && !(zen[k] && a == 2'd0);
    endfunction

    function automatic logic [1:0] m_fwd(int k, bit used, logic [1:0] rs);
        ins_t older [2];
        older[0] = m_mem[k];
        older[1] = m_wb[k];
        if (!m_ex[k].valid || !used) return 2'd0;
        for (int i = 0; i < 2; i++)
            if (older[i].valid && older[i].we && same(k, older[i].rd, rs)) return 2'(i + 1);
        return 2'd0;
    endfunction

    function automatic bit m_hz(int k);
        ins_t e = m_ex[k];
        return id_valid && e.valid && e.ld && e.we &&
               ((id_rs1_used && same(k, id_rs1, e.rd)) || (id_rs2_used && same(k, id_rs2, e.rd)));
    endfunction

    function automatic bit m_stall(int k);
        return !br && (left[k] > 0 || m_hz(k));
    endfunction

    task automatic eval();
        #1;
        for (int k = 0; k < 3; k++) begin
            bit s = m_stall(k);
            chk($sformatf("d%0d pc_write_en", k), o_pcwe[k], !s);
            chk($sformatf("d%0d if_id_write_en", k), o_ifwe[k], !s);
            chk($sformatf("d%0d if_id_flush", k), o_flush[k], br);
            chk($sformatf("d%0d id_ex_bubble", k), o_bub[k], br || s);
            chk($sformatf("d%0d stall_active", k), o_stall[k], s);
            chk($sformatf("d%0d fwd_a_sel", k), o_fa[k], m_fwd(k, m_ex[k].u1, m_ex[k].rs1));
            chk($sformatf("d%0d fwd_b_sel", k), o_fb[k], m_fwd(k, m_ex[k].u2, m_ex[k].rs2));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            bit   hz  = m_hz(k);
            bit   bub = br || m_stall(k);
            ins_t id  = '{valid: id_valid && !bub, rd: id_rd, we: id_we, ld: id_is_load,
                          rs1: id_rs1, rs2: id_rs2, u1: id_rs1_used, u2: id_rs2_used};
            if (rst) begin
                m_ex[k].valid = 0; m_mem[k].valid = 0; m_wb[k].valid = 0; left[k] = 0;
            end else begin
                m_wb[k]  = m_mem[k];
                m_mem[k] = m_ex[k];
                m_ex[k]  = id;
                if (br)               left[k] = 0;
                else if (left[k] > 0) left[k]--;
                else if (hz)          left[k] = int'(stalls[k]) - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic set_id(input bit v, input logic [1:0] rs1, input logic [1:0] rs2,
                          input bit u1, input bit u2, input logic [1:0] rd, input bit we,
                          input bit ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_is_load = ld;
    endtask

    task automatic nop();
        set_id(0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0);
    endtask

    task automatic rand_id();
        set_id(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_ex[k].valid = 0; m_mem[k].valid = 0; m_wb[k].valid = 0; left[k] = 0;
        end
        rst = 1'b1; br = 1'b0;
        rand_id();
        @(negedge clk);
        rand_id();
        @(negedge clk);
        // Reset held for two edges; state is clean whatever ID shows.
        rand_id();
        eval();
        chk("rst pc_write_en", o_pcwe[1], 1'b1);
        chk("rst if_id_write_en", o_ifwe[1], 1'b1);
        chk("rst fwd_a_sel", o_fa[1], 2'b00);
        chk("rst fwd_b_sel", o_fb[1], 2'b00);
        chk("rst stall_active", o_stall[1], 1'b0);
        adv();
        rst = 1'b0;
        nop(); step(); step(); step();

        // ALU chain, back to back: MEM forwarding on both operands.
        set_id(1, 2'd2, 2'd3, 1, 1, 2'd1, 1, 0); step();
        set_id(1, 2'd1, 2'd1, 1, 1, 2'd0, 0, 0); step();
        nop(); eval();
        chk("alu mem fwd_a", o_fa[0], 2'b01);
        chk("alu mem fwd_b", o_fb[0], 2'b01);
        adv(); step(); step();

        // ALU chain with one independent instruction between: WB forwarding.
        set_id(1, 2'd2, 2'd3, 1, 1, 2'd1, 1, 0); step();
        set_id(1, 2'd3, 2'd3, 1, 1, 2'd2, 1, 0); step();
        set_id(1, 2'd1, 2'd1, 1, 1, 2'd0, 0, 0); step();
        nop(); eval();
        chk("alu wb fwd_a", o_fa[0], 2'b10);
        chk("alu wb fwd_b", o_fb[0], 2'b10);
        adv(); step(); step();

        // Two writes to R2 then a reader: MEM result wins over WB.
        set_id(1, 2'd0, 2'd0, 0, 0, 2'd2, 1, 0); step();
        set_id(1, 2'd0, 2'd0, 0, 0, 2'd2, 1, 0); step();
        set_id(1, 2'd2, 2'd0, 1, 0, 2'd0, 0, 0); step();
        nop(); eval();
        chk("prio fwd_a", o_fa[0], 2'b01);
        adv(); step(); step();

        // Load-use: LD R3 then ADD reading rs2 = 3, held in ID while stalled.
        set_id(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 1); step();
        set_id(1, 2'd0, 2'd3, 0, 1, 2'd0, 0, 0);
        eval();
        chk("lu1 c1 pc_write_en", o_pcwe[0], 1'b0);
        chk("lu1 c1 id_ex_bubble", o_bub[0], 1'b1);
        chk("lu3 c1 pc_write_en", o_pcwe[1], 1'b0);
        adv(); eval();
        chk("lu1 c2 pc_write_en", o_pcwe[0], 1'b1);
        chk("lu3 c2 pc_write_en", o_pcwe[1], 1'b0);
        adv(); eval();
        chk("lu1 wb fwd_b", o_fb[0], 2'b10);
        chk("lu3 c3 pc_write_en", o_pcwe[1], 1'b0);
        chk("lu3 c3 stall_active", o_stall[1], 1'b1);
        adv(); eval();
        chk("lu3 c4 pc_write_en", o_pcwe[1], 1'b1);
        adv();
        nop(); step(); step(); step();

        // Taken branch in the same cycle as a load-use hazard.
        set_id(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 1); step();
        set_id(1, 2'd0, 2'd3, 0, 1, 2'd0, 0, 0);
        br = 1'b1;
        eval();
        chk("br if_id_flush", o_flush[1], 1'b1);
        chk("br id_ex_bubble", o_bub[1], 1'b1);
        chk("br pc_write_en", o_pcwe[1], 1'b1);
        chk("br stall_active", o_stall[1], 1'b0);
        adv();
        br = 1'b0;
        eval();
        chk("br next stall_active", o_stall[1], 1'b0);
        adv();
        nop(); step(); step(); step();

        // Reset in the 2nd cycle of a 3-cycle stall aborts it.
        set_id(1, 2'd0, 2'd0, 0, 0, 2'd3, 1, 1); step();
        set_id(1, 2'd0, 2'd3, 0, 1, 2'd0, 0, 0); step();
        rst = 1'b1;
        eval();
        chk("rst mid stall before", o_stall[1], 1'b1);
        adv();
        rst = 1'b0;
        eval();
        chk("rst mid stall_active", o_stall[1], 1'b0);
        chk("rst mid fwd_a_sel", o_fa[1], 2'b00);
        chk("rst mid fwd_b_sel", o_fb[1], 2'b00);
        adv();
        nop(); step(); step(); step();

        // R0 writes are not forwarded when masking is enabled.
        set_id(1, 2'd1, 2'd1, 0, 0, 2'd0, 1, 0); step();
        set_id(1, 2'd0, 2'd1, 1, 0, 2'd1, 0, 0); step();
        nop(); eval();
        chk("r0 fwd unmasked", o_fa[0], 2'b01);
        chk("r0 fwd masked", o_fa[2], 2'b00);
        adv(); step(); step();

        // Random traffic with occasional branches and resets.
        for (int i = 0; i < 400; i++) begin
            rand_id();
            br  = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
